// File: rtl/mult_pkg.sv
// Shared types and arithmetic for the multiplier product path.
// Holds default widths and the saturating adder function.
package mult_pkg;

   localparam int PROD_W    = 8;
   localparam int ACC_W_DEF = 16;
   localparam int SAT_W     = 64;

   // Returns {carry, clamped_sum}; the sum is all-ones of width w on carry.
   function automatic logic [SAT_W:0] sat_add(
      input logic [SAT_W-1:0] acc,
      input logic [SAT_W-1:0] prod,
      input int               w
   );
      logic [SAT_W:0]   s;
      logic [SAT_W-1:0] mask;
      logic             c;
      mask = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
      s    = {1'b0, acc} + {1'b0, prod};
      c    = (w >= SAT_W) ? s[SAT_W] : |(s[SAT_W-1:0] & ~mask);
      return {c, (c ? mask : s[SAT_W-1:0])};
   endfunction

endpackage

// File: rtl/product_sat_add.sv
// Combinational saturating adder: accumulator plus zero-extended product.
// Clamps to all-ones and flags carry on overflow.
module product_sat_add
   import mult_pkg::*;
#(
   parameter int IN_W  = PROD_W,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [IN_W-1:0]  product,
   output logic [ACC_W-1:0] nxt,
   output logic             carry
);

   logic [SAT_W:0] res;
   logic           unused_hi;

   assign res       = sat_add(SAT_W'(acc), SAT_W'(product), ACC_W);
   assign carry     = res[SAT_W];
   assign nxt       = res[ACC_W-1:0];
   assign unused_hi = ^res[SAT_W-1:ACC_W];

endmodule

// File: rtl/product_accum_stage.sv
// Sums groups of COUNT products with saturation and presents each
// group sum on a registered valid/ready output.
module product_accum_stage
   import mult_pkg::*;
#(
   parameter int IN_W  = PROD_W,
   parameter int ACC_W = ACC_W_DEF,
   parameter int COUNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  product,
   output logic             in_ready,
   input  logic             clear,
   output logic [ACC_W-1:0] sum,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic             sat
);

   localparam int CNT_W = $clog2(COUNT);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] nxt;
   logic [CNT_W-1:0] cnt;
   logic             sat_acc;
   logic             carry;
   logic             last;
   logic             take;
   logic             pop;

   product_sat_add #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
   ) u_add (
      .acc     (acc),
      .product (product),
      .nxt     (nxt),
      .carry   (carry)
   );

   assign last = (cnt == CNT_W'(COUNT - 1));
   // Only the group-closing product stalls on a full output register.
   assign in_ready = ena && !clear
                     && !(last && sum_valid && !sum_ready);
   assign take = in_valid && in_ready;
   assign pop  = sum_valid && sum_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         sat_acc   <= 1'b0;
         sum       <= '0;
         sum_valid <= 1'b0;
         sat       <= 1'b0;
      end else begin
         if (clear) begin
            acc     <= '0;
            cnt     <= '0;
            sat_acc <= 1'b0;
         end else if (take) begin
            if (last) begin
               acc     <= '0;
               cnt     <= '0;
               sat_acc <= 1'b0;
            end else begin
               acc     <= nxt;
               cnt     <= cnt + CNT_W'(1);
               sat_acc <= sat_acc | carry;
            end
         end

         if (take && last) begin
            sum       <= nxt;
            sat       <= sat_acc | carry;
            sum_valid <= 1'b1;
         end else if (pop) begin
            sum_valid <= 1'b0;
         end
      end
   end

endmodule
